// File: rtl/io_port_arbiter.sv
// Purpose: shares the single-ported memory-mapped I/O block between r0 (CPU MEM stage) and r1 (aux master); optional IO_ARB_RR_EN selects round-robin.
// Latency: gnt one cycle after an IDLE arbitration; writes take 2 cycles per transaction, reads take 3 (rvalid in N+3).
// Backpressure: requests are level-held until gnt; requests seen while busy are ignored and served at the next IDLE.
module io_port_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] io_addr,
  output logic              io_we,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t state;
  logic   owner;    // requester whose transaction is in flight
  logic   win;      // arbitration result: 0 = r0, 1 = r1
  logic   any_req;

`ifdef IO_ARB_RR_EN
  // Last-granted requester; reset value 1 gives r0 priority first.
  logic   rr_last;

  // Round-robin pick: on contention the requester not granted last wins.
  always_comb begin
    any_req = r0_req | r1_req;
    win     = r1_req & (~r0_req | ~rr_last);
  end
`else
  localparam int SW = $clog2(HOLD_MAX + 1);
  localparam logic [SW-1:0] HOLD_CAP = SW'(HOLD_MAX);

  // Consecutive r0 grants taken while r1 was waiting.
  logic [SW-1:0] streak;

  // Fixed r0 priority, overridden once r1 has waited HOLD_MAX r0 grants.
  always_comb begin
    any_req = r0_req | r1_req;
    win     = r1_req & (~r0_req | (streak == HOLD_CAP));
  end
`endif

  // Transaction sequencer: arbitrate in IDLE, drive the I/O block in ISSUE, return read data after WAIT_RD.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      owner     <= 1'b0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      io_we     <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= '0;
`ifdef IO_ARB_RR_EN
      rr_last   <= 1'b1;
`else
      streak    <= '0;
`endif
    end else begin
      // Pulses default low; io_we is high only for the ISSUE cycle of a write.
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      io_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= win;
            io_we    <= win ? r1_we    : r0_we;
            io_addr  <= win ? r1_addr  : r0_addr;
            io_wdata <= win ? r1_wdata : r0_wdata;
            r0_gnt   <= ~win;
            r1_gnt   <= win;
            state    <= ISSUE;
            busy     <= 1'b1;
`ifdef IO_ARB_RR_EN
            rr_last  <= win;
`endif
          end
`ifndef IO_ARB_RR_EN
          // The guard only counts while r1 is actually being held off.
          if (!r1_req || win) begin
            streak <= '0;
          end else if (streak != HOLD_CAP) begin
            streak <= streak + 1'b1;
          end
`endif
        end
        ISSUE: begin
          // io_we still holds the latched command type during ISSUE.
          if (io_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // The I/O block's registered read data is valid in this cycle.
          if (owner) begin
            r1_rdata  <= io_rdata;
            r1_rvalid <= 1'b1;
          end else begin
            r0_rdata  <= io_rdata;
            r0_rvalid <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_arbiter.sv
// Bench for io_port_arbiter: a transaction-level schedule model predicts every output cycle by cycle.
// Directed cases first, then contention, r1-only and randomized traffic with occasional resets.
// Requesters are driven from the model's own grant prediction, so stimulus never depends on the DUT.
module tb_io_port_arbiter;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int HOLD_MAX = 4;
  localparam int MAXC     = 4000;
  localparam int M_IDLE   = 0;
  localparam int M_RAND   = 1;
  localparam int M_BOTHRD = 2;
  localparam int M_R1     = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic [ADDR_W-1:0] io_addr;
  logic              io_we;
  logic [DATA_W-1:0] io_wdata, io_rdata;
  logic              busy;

  io_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .io_addr(io_addr), .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural I/O block: write on the clock edge, registered read data.
  logic [DATA_W-1:0] iomem [32];
  always @(posedge clock) begin
    if (io_we) iomem[io_addr] <= io_wdata;
    io_rdata <= iomem[io_addr];
  end

  // Reference model state: per-cycle expectation schedule.
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int free_at = 0;
  int streak = 0;
  int last_gnt = 1;
  bit pend [2];
  bit cwe [2];
  logic [ADDR_W-1:0] caddr [2];
  logic [DATA_W-1:0] cwd [2];
  logic [DATA_W-1:0] refmem [32];
  bit exp_gnt [2][MAXC];
  bit exp_rv [2][MAXC];
  logic [DATA_W-1:0] rv_val [2][MAXC];
  bit exp_iowe [MAXC];
  bit exp_busy [MAXC];
  logic [DATA_W-1:0] exp_wd [MAXC];
  bit addr_set [MAXC];
  logic [ADDR_W-1:0] addr_val [MAXC];
  bit rd_clr [MAXC];
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_rdata [2];
  int order [$];

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one cycle and compare every output with the schedule.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (addr_set[cyc]) m_addr = addr_val[cyc];
    for (int i = 0; i < 2; i++) begin
      if (rd_clr[cyc]) m_rdata[i] = '0;
      if (exp_rv[i][cyc]) m_rdata[i] = rv_val[i][cyc];
    end
    chk("r0_gnt", 32'(r0_gnt), 32'(exp_gnt[0][cyc]));
    chk("r1_gnt", 32'(r1_gnt), 32'(exp_gnt[1][cyc]));
    chk("r0_rvalid", 32'(r0_rvalid), 32'(exp_rv[0][cyc]));
    chk("r1_rvalid", 32'(r1_rvalid), 32'(exp_rv[1][cyc]));
    chk("io_we", 32'(io_we), 32'(exp_iowe[cyc]));
    chk("busy", 32'(busy), 32'(exp_busy[cyc]));
    chk("io_addr", 32'(io_addr), 32'(m_addr));
    chk("r0_rdata", r0_rdata, m_rdata[0]);
    chk("r1_rdata", r1_rdata, m_rdata[1]);
    if (exp_iowe[cyc]) chk("io_wdata", io_wdata, exp_wd[cyc]);
    if (r0_gnt) order.push_back(0);
    if (r1_gnt) order.push_back(1);
    for (int i = 0; i < 2; i++) if (exp_gnt[i][cyc]) pend[i] = 1'b0;
  endtask

  task automatic inject(input int i, input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pend[i] = 1'b1;
    cwe[i] = we;
    caddr[i] = a;
    cwd[i] = d;
  endtask

  task automatic gen(input int mode);
    for (int i = 0; i < 2; i++) begin
      if (!pend[i]) begin
        case (mode)
          M_RAND:   if ($urandom_range(0, 2) == 0) inject(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
          M_BOTHRD: inject(i, 1'b0, 5'($urandom_range(0, 31)), $urandom);
          M_R1:     if (i == 1 && $urandom_range(0, 1) == 0) inject(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
          default:  ;
        endcase
      end
    end
  endtask

  // Idle requesters present junk command fields to show they are ignored.
  task automatic drive();
    r0_req   = pend[0];
    r0_we    = pend[0] ? cwe[0]   : 1'($urandom);
    r0_addr  = pend[0] ? caddr[0] : 5'($urandom);
    r0_wdata = pend[0] ? cwd[0]   : $urandom;
    r1_req   = pend[1];
    r1_we    = pend[1] ? cwe[1]   : 1'($urandom);
    r1_addr  = pend[1] ? caddr[1] : 5'($urandom);
    r1_wdata = pend[1] ? cwd[1]   : $urandom;
  endtask

  // Transaction-level arbitration: pick winner by rule, schedule its whole timeline.
  task automatic arbitrate();
    int w;
    if (cyc < free_at) return;
    if (!pend[0] && !pend[1]) begin
      streak = 0;
      return;
    end
`ifdef IO_ARB_RR_EN
    if (pend[0] && pend[1]) w = (last_gnt == 0) ? 1 : 0;
    else w = pend[1] ? 1 : 0;
    last_gnt = w;
`else
    w = (pend[1] && (!pend[0] || streak == HOLD_MAX)) ? 1 : 0;
    if (w == 1 || !pend[1]) streak = 0;
    else if (streak < HOLD_MAX) streak++;
`endif
    exp_gnt[w][cyc+1] = 1'b1;
    exp_busy[cyc+1] = 1'b1;
    addr_set[cyc+1] = 1'b1;
    addr_val[cyc+1] = caddr[w];
    if (cwe[w]) begin
      exp_iowe[cyc+1] = 1'b1;
      exp_wd[cyc+1] = cwd[w];
      refmem[caddr[w]] = cwd[w];
      free_at = cyc + 2;
    end else begin
      exp_busy[cyc+2] = 1'b1;
      exp_rv[w][cyc+3] = 1'b1;
      rv_val[w][cyc+3] = refmem[caddr[w]];
      free_at = cyc + 3;
    end
  endtask

  task automatic settle();
    reset = 1'b0;
    drive();
    arbitrate();
  endtask

  task automatic step(input int mode);
    tick();
    gen(mode);
    settle();
  endtask

  // Hold reset for one cycle; anything in flight is dropped from the schedule.
  task automatic do_reset();
    tick();
    reset = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
    for (int j = cyc + 1; j <= cyc + 3; j++) begin
      for (int i = 0; i < 2; i++) begin
        exp_gnt[i][j] = 1'b0;
        exp_rv[i][j] = 1'b0;
      end
      exp_iowe[j] = 1'b0;
      exp_busy[j] = 1'b0;
      addr_set[j] = 1'b0;
      rd_clr[j] = 1'b0;
    end
    addr_set[cyc+1] = 1'b1;
    addr_val[cyc+1] = '0;
    rd_clr[cyc+1] = 1'b1;
    free_at = cyc + 1;
    streak = 0;
    last_gnt = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_w;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      refmem[i] = $urandom;
      iomem[i] = refmem[i];
    end
    refmem[7] = 32'h2A5;
    iomem[7] = 32'h2A5;
    m_addr = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    drive();
    @(posedge clock);
    do_reset();

    // r0 write addr 3 data 0x15 from IDLE.
    tick(); inject(0, 1'b1, 5'd3, 32'h15); settle();
    repeat (4) step(M_IDLE);

    // r1 read addr 7 returns 0x2A5.
    tick(); inject(1, 1'b0, 5'd7, 32'h0); settle();
    repeat (5) step(M_IDLE);

    // r0 read addr 5, r1 write addr 0 arrives during WAIT_RD.
    tick(); inject(0, 1'b0, 5'd5, 32'h0); settle();
    step(M_IDLE);
    tick(); inject(1, 1'b1, 5'd0, 32'hCAFE_0001); settle();
    repeat (6) step(M_IDLE);

    // Reset in WAIT_RD of an r0 read, then a normal r0 write.
    tick(); inject(0, 1'b0, 5'd9, 32'h0); settle();
    step(M_IDLE);
    do_reset();
    step(M_IDLE);
    tick(); inject(0, 1'b1, 5'd12, 32'h1234_5678); settle();
    repeat (4) step(M_IDLE);

    // Both requesters hold reads continuously.
    do_reset();
    order.delete();
    repeat (45) step(M_BOTHRD);
    chk("order_len_ok", 32'(order.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < order.size(); i++) begin
`ifdef IO_ARB_RR_EN
      exp_w = i % 2;
`else
      exp_w = ((i % (HOLD_MAX + 1)) == HOLD_MAX) ? 1 : 0;
`endif
      chk($sformatf("grant_order[%0d]", i), 32'(order[i]), 32'(exp_w));
    end
    repeat (12) step(M_IDLE);

    // r1 alone.
    repeat (80) step(M_R1);
    repeat (6) step(M_IDLE);

    // Randomized mixed traffic with occasional resets.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(M_RAND);
    end
    repeat (10) step(M_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
